spi_flash_responder: RTL and testbench

//  SPI mode-0 target that emulates a small serial NOR flash. It sits opposite the external flash

---
 rtl/spi_flash_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 target emulating a small serial NOR flash so the flash
//   controller's SPI master can be exercised on-chip. SPI pins are
//   oversampled in the hclk_i domain. The backing store is an internal byte
//   array that can be preloaded through a side port; it is never reset.
//
// Ports
//   hclk_i       system clock (SCK half-period >= SYNC_STAGES+2 hclk)
//   hreset_i     synchronous active-high reset
//   sck_i        SPI clock, idle low
//   mosi_i       master-out data, MSB first
//   ssn_i        active-low chip select
//   miso_o       target-out data
//   init_we_i    preload write strobe (ignored while ssn_i low)
//   init_addr_i  preload byte address
//   init_data_i  preload byte
//   busy_o       high while a transaction is in progress
//
// Configuration
//   SPI_FLASH_FAST_READ_EN  when defined, opcode 0x0B (FAST READ with 8
//                           dummy clocks) is accepted; otherwise it is
//                           treated as an unknown opcode.
module spi_flash_responder #(
    parameter int ADDR_WIDTH  = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    input  logic                  ssn_i,
    output logic                  miso_o,
    input  logic                  init_we_i,
    input  logic [ADDR_WIDTH-1:0] init_addr_i,
    input  logic [7:0]            init_data_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STATUS, S_IGNORE, S_DUMMY
    } state_t;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_PROG = 2'd1;
    localparam logic [1:0] OP_FAST = 2'd2;

    logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ssn_sync;
    logic                   sck_prev, ssn_prev;
    logic                   sck_s, mosi_s, ssn_s;
    logic                   sck_rise, sck_fall, ssn_rise, ssn_fall;

    state_t                 state;
    logic [1:0]             op_kind;
    logic [4:0]             bit_cnt;
    logic [6:0]             shift_in;
    logic [7:0]             tx_shift;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   wel;
    logic                   miso_q;

    logic [7:0]             rx_byte;
    logic [ADDR_WIDTH-1:0]  addr_shift, addr_inc;
    logic [7:0]             status_byte;
    logic                   spi_we;

    // Synchronisers reset low so that a chip select already asserted when
    // reset releases is not mistaken for a fresh ssn fall.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ssn_sync  <= '0;
            sck_prev  <= 1'b0;
            ssn_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn_i};
            sck_prev  <= sck_s;
            ssn_prev  <= ssn_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ssn_s    = ssn_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign ssn_rise = ssn_s & ~ssn_prev;
    assign ssn_fall = ~ssn_s & ssn_prev;

    assign rx_byte     = {shift_in, mosi_s};
    assign addr_shift  = {addr[ADDR_WIDTH-2:0], mosi_s};
    assign addr_inc    = addr + 1'b1;
    assign status_byte = {6'b0, wel, 1'b0};

    // A byte is committed only on its 8th rising edge, so partial bytes
    // cut off by ssn never reach the store.
    assign spi_we = !hreset_i && !ssn_s && state == S_PROG && sck_rise && bit_cnt == 5'd7;

    // SPI program write takes priority over preload.
    always_ff @(posedge hclk_i) begin
        if (spi_we)
            mem[addr] <= rx_byte;
        else if (init_we_i && ssn_i)
            mem[init_addr_i] <= init_data_i;
    end

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state    <= S_IDLE;
            op_kind  <= OP_READ;
            bit_cnt  <= '0;
            shift_in <= '0;
            tx_shift <= '0;
            addr     <= '0;
            wel      <= 1'b0;
            miso_q   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            if (ssn_rise && state == S_PROG)
                wel <= 1'b0;
            if (ssn_s) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                miso_q  <= 1'b0;
                busy_o  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (ssn_fall) begin
                        state    <= S_CMD;
                        bit_cnt  <= '0;
                        tx_shift <= '0;
                        miso_q   <= 1'b0;
                        busy_o   <= 1'b1;
                    end
                    S_CMD: if (sck_rise) begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            case (rx_byte)
                                8'h03: begin op_kind <= OP_READ; state <= S_ADDR; end
                                8'h02: begin
                                    op_kind <= OP_PROG;
                                    state   <= wel ? S_ADDR : S_IGNORE;
                                end
                                8'h05: begin tx_shift <= status_byte; state <= S_STATUS; end
                                8'h06: begin wel <= 1'b1; state <= S_IGNORE; end
                                8'h04: begin wel <= 1'b0; state <= S_IGNORE; end
`ifdef SPI_FLASH_FAST_READ_EN
                                8'h0B: begin op_kind <= OP_FAST; state <= S_ADDR; end
`endif
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (sck_rise) begin
                        addr    <= addr_shift;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            case (op_kind)
                                OP_PROG: state <= S_PROG;
                                OP_FAST: state <= S_DUMMY;
                                default: begin
                                    tx_shift <= mem[addr_shift];
                                    state    <= S_READ;
                                end
                            endcase
                        end
                    end
                    S_DUMMY: if (sck_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt  <= '0;
                            tx_shift <= mem[addr];
                            state    <= S_READ;
                        end
                    end
                    S_READ, S_STATUS: begin
                        // Reload on the 8th rise so the next byte's MSB goes
                        // out on the following fall with no gap.
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                if (state == S_READ) begin
                                    addr     <= addr_inc;
                                    tx_shift <= mem[addr_inc];
                                end else begin
                                    tx_shift <= status_byte;
                                end
                            end
                        end else if (sck_fall) begin
                            miso_q   <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    S_PROG: if (sck_rise) begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr_inc;
                        end
                    end
                    default: miso_q <= 1'b0;
                endcase
            end
        end
    end

    // The raw chip select gates the output so miso is quiet the moment the
    // master deselects, without waiting for the synchroniser.
    assign miso_o = miso_q & ~ssn_i;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    localparam int AW   = 14;
    localparam int HALF = 8;

    logic          hclk_i = 1'b0;
    logic          hreset_i;
    logic          sck_i, mosi_i, ssn_i;
    logic          miso_o;
    logic          init_we_i;
    logic [AW-1:0] init_addr_i;
    logic [7:0]    init_data_i;
    logic          busy_o;

    int            pass_cnt  = 0;
    int            fail_cnt  = 0;
    int            total_cnt = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    rx;

    spi_flash_responder #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .hclk_i      (hclk_i),
        .hreset_i    (hreset_i),
        .sck_i       (sck_i),
        .mosi_i      (mosi_i),
        .ssn_i       (ssn_i),
        .miso_o      (miso_o),
        .init_we_i   (init_we_i),
        .init_addr_i (init_addr_i),
        .init_data_i (init_data_i),
        .busy_o      (busy_o)
    );

    always #5 hclk_i = ~hclk_i;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge hclk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total_cnt++;
        assert (obs === want) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        init_we_i   = 1'b1;
        init_addr_i = a;
        init_data_i = d;
        wait_clk(1);
        init_we_i   = 1'b0;
    endtask

    // Mode-0 master: drive mosi while sck low, sample miso just before rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi_i = tx[7-i];
            wait_clk(HALF);
            r = {r[6:0], miso_o};
            sck_i = 1'b1;
            wait_clk(HALF);
            sck_i = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] dummy;
        spi_bits(tx, 8, dummy);
    endtask

    task automatic start();
        ssn_i = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic stop();
        wait_clk(HALF);
        ssn_i  = 1'b1;
        mosi_i = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
        send(op);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    // Clock one byte out of the DUT and compare it to the scoreboard head.
    task automatic rx_byte(input string tag);
        logic [7:0] r;
        spi_bits(8'h00, 8, r);
        if (exp_q.size() == 0) begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL %s: got %0h with empty scoreboard", tag, r);
        end else begin
            check(tag, {24'h0, r}, {24'h0, exp_q.pop_front()});
        end
    endtask

    initial begin
        hreset_i    = 1'b1;
        sck_i       = 1'b0;
        mosi_i      = 1'b0;
        ssn_i       = 1'b1;
        init_we_i   = 1'b0;
        init_addr_i = '0;
        init_data_i = '0;
        wait_clk(5);
        check("reset_miso", {31'h0, miso_o}, 32'h0);
        check("reset_busy", {31'h0, busy_o}, 32'h0);
        hreset_i = 1'b0;
        wait_clk(4);

        // 1: basic read stream
        preload(14'h0010, 8'hA5);
        preload(14'h0011, 8'h5A);
        preload(14'h0012, 8'h01);
        preload(14'h0013, 8'hFE);
        start();
        cmd_addr(8'h03, 24'h000010);
        check("busy_active", {31'h0, busy_o}, 32'h1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        repeat (4) rx_byte("t1_read");
        stop();
        check("idle_busy", {31'h0, busy_o}, 32'h0);
        check("idle_miso", {31'h0, miso_o}, 32'h0);

        // 2: address wrap at top of store, upper address bits ignored
        preload(14'h3FFF, 8'h11);
        preload(14'h0000, 8'h22);
        start();
        cmd_addr(8'h03, 24'hFC3FFF);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        repeat (2) rx_byte("t2_wrap");
        stop();

        // 3: program needs WREN
        preload(14'h0100, 8'h77);
        preload(14'h0101, 8'h88);
        start(); cmd_addr(8'h02, 24'h000100); send(8'hDE); send(8'hAD); stop();
        start(); cmd_addr(8'h03, 24'h000100);
        exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        repeat (2) rx_byte("t3_noprog");
        stop();
        start(); send(8'h06); stop();
        start(); cmd_addr(8'h02, 24'h000100); send(8'hDE); send(8'hAD); stop();
        start(); send(8'h05);
        exp_q.push_back(8'h00);
        rx_byte("t3_status_after_prog");
        stop();
        start(); cmd_addr(8'h03, 24'h000100);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        repeat (2) rx_byte("t3_prog_read");
        stop();

        // 4: WEL visible in status; partial byte discarded; WEL cleared by PROG end
        preload(14'h0200, 8'h00);
        preload(14'h0201, 8'h99);
        start(); send(8'h06); stop();
        start(); send(8'h05);
        exp_q.push_back(8'h02); exp_q.push_back(8'h02);
        repeat (2) rx_byte("t4_status_wel");
        stop();
        start(); cmd_addr(8'h02, 24'h000200); send(8'h3C); spi_bits(8'hC3, 4, rx); stop();
        start(); send(8'h05);
        exp_q.push_back(8'h00);
        rx_byte("t4_status_clr");
        stop();
        start(); cmd_addr(8'h03, 24'h000200);
        exp_q.push_back(8'h3C); exp_q.push_back(8'h99);
        repeat (2) rx_byte("t4_partial");
        stop();

        // 5: unknown opcode stays silent; following read works
        start(); send(8'h9F);
        repeat (4) exp_q.push_back(8'h00);
        repeat (4) rx_byte("t5_unknown");
        stop();
        start(); cmd_addr(8'h03, 24'h000012);
        exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        repeat (2) rx_byte("t5_read_after");
        stop();

        // 5b: reset in the middle of a read, chip select still low
        start(); cmd_addr(8'h03, 24'h000010);
        exp_q.push_back(8'hA5);
        rx_byte("t5_pre_reset");
        spi_bits(8'h00, 3, rx);
        hreset_i = 1'b1;
        wait_clk(3);
        hreset_i = 1'b0;
        wait_clk(2);
        check("t5_reset_busy", {31'h0, busy_o}, 32'h0);
        check("t5_reset_miso", {31'h0, miso_o}, 32'h0);
        stop();
        start(); cmd_addr(8'h03, 24'h000010);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        repeat (2) rx_byte("t5_store_intact");
        stop();

        // 6: fast read (zeros when the option is absent)
        start(); cmd_addr(8'h0B, 24'h000010);
        exp_q.push_back(8'h00);
`ifdef SPI_FLASH_FAST_READ_EN
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
`else
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`endif
        repeat (3) rx_byte("t6_fast_read");
        stop();

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
